// File: rtl/ring_rr_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encodings
// and the requester/resource ids that the downstream port mux decodes.
package ring_rr_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Requester slots on the data-memory port (index into req/gnt)
  localparam int RES_ID_W = 2;
  localparam logic [RES_ID_W-1:0] RES_CORE  = 2'd0;
  localparam logic [RES_ID_W-1:0] RES_DMA   = 2'd1;
  localparam logic [RES_ID_W-1:0] RES_DEBUG = 2'd2;
  localparam logic [RES_ID_W-1:0] RES_IO    = 2'd3;

  // Default arbiter geometry
  localparam int ARB_N_REQ_DEF    = 4;
  localparam int ARB_MAX_HOLD_DEF = 16;
  localparam int ARB_IDW_DEF      = 2;

endpackage : ring_rr_arbiter_pkg

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the ring arbiter.
// master = requester side (drives req/done), slave = arbiter side.
interface ring_rr_arbiter_if
  import ring_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ_DEF,
  parameter int IDW   = ARB_IDW_DEF
) ();

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic             preempt;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_vld,
    input  gnt_id,
    input  preempt
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_vld,
    output gnt_id,
    output preempt
  );

endinterface : ring_rr_arbiter_if

// File: rtl/ring_rr_arbiter_pick.sv
// Combinational ring picker: finds the first asserted request at or after
// ptr, wrapping around the ring. Implemented as rotate-right by ptr, a
// fixed low-index-first priority encode, then adding ptr back (mod N_REQ
// through natural IDW-bit wrap).
module rr_ring_pick
  import ring_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ_DEF,
  parameter int IDW   = ARB_IDW_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IDW-1:0]   rot_idx;
  logic             rot_found;

  // Rotated view: rot[i] is the request that sits i steps after ptr
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    localparam logic [IDW-1:0] OFS = IDW'(gi);
    logic [IDW-1:0] src_idx;
    assign src_idx = OFS + ptr;
    assign rot[gi] = req[src_idx];
  end

  // Fixed-priority encode of the rotated vector, lowest index wins
  always_comb begin
    rot_idx   = '0;
    rot_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_idx   = IDW'(i);
        rot_found = 1'b1;
      end
    end
  end

  assign winner = rot_idx + ptr;
  assign any    = rot_found;

endmodule : rr_ring_pick

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter for the single-ported data-memory resource.
// An owner keeps the grant until it signals done, drops its request or
// reaches the hold limit; every release is followed by one idle cycle
// before the next grant, and the search pointer moves to the slot after
// the released owner so priority rotates around the ring.
module ring_rr_arbiter
  import ring_rr_arbiter_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
  parameter int IDW      = ARB_IDW_DEF
) (
  input logic               clk,
  input logic               rst,
  ring_rr_arbiter_if.slave  bus
);

  // Hold counter only needs to reach MAX_HOLD-1; with the limit disabled
  // it simply saturates at all-ones and never triggers a release.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             gnt_vld_reg;
  logic [IDW-1:0]   gnt_id_reg;
  logic             preempt_reg;

  logic [IDW-1:0]   pick_winner;
  logic             pick_any;
  logic             owner_req;
  logic             hold_hit;
  logic             release_now;

  rr_ring_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Release causes, evaluated against the current owner
  assign owner_req   = bus.req[gnt_id_reg];
  assign hold_hit    = (MAX_HOLD != 0) && (cnt_reg == CNT_MAX);
  assign release_now = bus.done || !owner_req || hold_hit;

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      gnt_vld_reg <= 1'b0;
      gnt_id_reg  <= '0;
      preempt_reg <= 1'b0;
    end else begin
      preempt_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          // done is meaningless without an owner, so only req matters here
          if (pick_any) begin
            gnt_reg     <= N_REQ'(1) << pick_winner;
            gnt_vld_reg <= 1'b1;
            gnt_id_reg  <= pick_winner;
            cnt_reg     <= '0;
            state_reg   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (release_now) begin
            gnt_reg     <= '0;
            gnt_vld_reg <= 1'b0;
            ptr_reg     <= gnt_id_reg + IDW'(1);
            // Flag only releases that the owner did not ask for
            preempt_reg <= hold_hit && !bus.done && owner_req;
            state_reg   <= ARB_IDLE;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg   <= ARB_IDLE;
          gnt_reg     <= '0;
          gnt_vld_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_vld = gnt_vld_reg;
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.preempt = preempt_reg;

endmodule : ring_rr_arbiter

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N_REQ=4, MAX_HOLD=16): a table of
// per-cycle vectors plus hand sequences for async reset, hold limit and
// simultaneous release causes.
module tb_ring_rr_arbiter;

  logic clk;
  logic rst;

  ring_rr_arbiter_if #(.N_REQ(4), .IDW(2)) bus ();

  ring_rr_arbiter #(
    .N_REQ    (4),
    .MAX_HOLD (16),
    .IDW      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic pre);
    chk({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    chk({tag, ".gnt_vld"}, 32'(bus.gnt_vld), 32'(|g));
    chk({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(id));
    chk({tag, ".preempt"}, 32'(bus.preempt), 32'(pre));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    // rst, req, done -> gnt, gnt_id, preempt (outputs after that edge)
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    // single requester 2; done releases, ptr=3 wraps back to 2
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
    tbl[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
    // owner drops request -> release, id held while idle
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
    // ptr=3, req 0011 -> 0 then 1
    tbl[8]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 4'b0011, 1'b1, 4'b0000, 2'd1, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
    // reset back to ptr=0, then rotation with done always high
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[16] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0};
    tbl[17] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0};
    tbl[18] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0};
    tbl[19] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0};
    tbl[20] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[21] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0};
    tbl[22] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[23] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[24] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

    #1;
    for (int v = 0; v < NV; v++) begin
      rst      = tbl[v].rst;
      bus.req  = tbl[v].req;
      bus.done = tbl[v].done;
      tick();
      chk_all($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].id, tbl[v].pre);
      $display("vec %0d: req=%b done=%b -> gnt=%b id=%0d pre=%b", v, tbl[v].req,
               tbl[v].done, bus.gnt, bus.gnt_id, bus.preempt);
    end

    // Async reset mid-BUSY: grant to 2 drops before the next edge
    bus.req = 4'b0100;
    tick();
    chk_all("rst_pre", 4'b0100, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("rst_async", 4'b0000, 2'd0, 1'b0);
    $display("async reset: gnt=%b id=%0d", bus.gnt, bus.gnt_id);
    tick();
    rst = 1'b0;

    // Hold limit: 16 granted cycles, preempt on release, re-grant after one idle
    bus.req  = 4'b0001;
    bus.done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    tick();
    chk_all("hold_rel", 4'b0000, 2'd0, 1'b1);
    $display("hold limit release: gnt=%b preempt=%b", bus.gnt, bus.preempt);
    tick();
    chk_all("hold_regnt", 4'b0001, 2'd0, 1'b0);

    // done coinciding with the hold limit: release without preempt
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_all($sformatf("hold2_%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    bus.done = 1'b1;
    tick();
    chk_all("done_at_limit", 4'b0000, 2'd0, 1'b0);
    $display("done at limit: gnt=%b preempt=%b", bus.gnt, bus.preempt);

    // Owner drops req on the same edge as done: ptr advances once
    bus.done = 1'b0;
    bus.req  = 4'b0011;
    tick();
    chk_all("drop_gnt", 4'b0010, 2'd1, 1'b0);
    bus.req  = 4'b0001;
    bus.done = 1'b1;
    tick();
    chk_all("drop_rel", 4'b0000, 2'd1, 1'b0);
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    tick();
    chk_all("drop_next", 4'b0100, 2'd2, 1'b0);
    $display("after drop+done: gnt=%b id=%0d", bus.gnt, bus.gnt_id);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ring_rr_arbiter
